led_bar_anim: RTL and testbench
===============================

# led_bar_anim

Parametrised LED-bar animation engine for the board front-panel display. Steps a WIDTH-bit LED pattern through one of four selectable sequences at a programmable step rate, with a blinking head LED while filling. Generalises the fixed 8-LED fill/drain animator with run/stop/pause control and a sequence-done pulse. Sits between the system clock domain and the LED pad drivers.

## Interface
- WIDTH, 8, number of LEDs (≥2)
- TICK_DIV, 4, clk cycles per animation step (≥1)
- BLINK_DIV, 2, clk cycles per head-blink half-period (≥1)
- clk  in  1  system clock, all logic posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin animation (sampled in IDLE only)
- stop  in  1  finish current sequence then go IDLE (sampled in RUN only)
- pause  in  1  freeze step position and tick counter while high
- mode  in  2  0 FILL_DRAIN, 1 CHASE, 2 BOUNCE, 3 BLINK_ALL
- led  out  WIDTH  registered LED pattern
- busy  out  1  high in RUN
- seq_done  out  1  one-cycle pulse when the sequence wraps to step 0

## Operation
- FSM states: IDLE, RUN. IDLE→RUN on start; RUN→IDLE on the step that would wrap pos to 0 after stop has been seen (stop is sticky once sampled in RUN).
- Mode latched into mode_q on IDLE→RUN and on every wrap; mode changes mid-sequence take effect at next wrap.
- pos counter, width clog2(2·WIDTH), advances by 1 on each tick; wraps at LEN−1 → 0.
- Sequences, k = pos:
  - FILL_DRAIN, LEN=2·WIDTH: k<WIDTH → bits [k-1:0] on, bit k = blink, above off; k≥WIDTH → low (2·WIDTH−1−k) bits on, no blink; k=2·WIDTH−1 → all off.
  - CHASE, LEN=WIDTH: led = 1<<k.
  - BOUNCE, LEN=2·WIDTH−2: k<WIDTH → 1<<k, else 1<<(2·WIDTH−2−k).
  - BLINK_ALL, LEN=2: k=0 all ones, k=1 all zeros.
- blink: free-running toggle every BLINK_DIV cycles from reset, independent of pause/state.
- IDLE: led=0, pos=0, tick counter=0.

## Timing
- Reset values: led=0, busy=0, seq_done=0, state IDLE, pos=0, tick cnt=0, blink=0, mode_q=0.
- start sampled at edge t → busy=1 and led shows step 0 from t+1.
- Tick asserts when tick cnt = TICK_DIV−1 (counter 0..TICK_DIV−1, runs only in RUN and !pause); pos updates on the following edge, led one edge later is NOT allowed — led is computed from next pos and registered in the same edge as pos.
- Each step therefore lasts exactly TICK_DIV cycles absent pause.
- seq_done high for exactly the cycle in which led shows step 0 after a wrap (not on initial start).
- stop + wrap on same edge: go IDLE, led=0, busy=0 next cycle; seq_done still pulses that cycle.
- pause high: pos, tick cnt, led hold except the FILL_DRAIN head bit continues to follow blink.
- start while RUN, stop while IDLE: ignored. start and stop together in IDLE: start wins, stop ignored.
- rst mid-operation: immediate return to reset values, no seq_done.

## Structure
- Package led_anim_pkg: mode enum (MODE_FILL_DRAIN, MODE_CHASE, MODE_BOUNCE, MODE_BLINK_ALL), state enum (ST_IDLE, ST_RUN).
- Sub-module step_tick (params DIV; in clk, rst, en, clr; out tick) used twice: step tick (en = RUN & !pause, clr = IDLE) and blink toggle enable (en=1).
- Pattern decode as a function of (mode_q, pos, blink, WIDTH) in the top module.

## Test plan
- WIDTH=8, TICK_DIV=4, mode 0, start: led sequence per 4-cycle step 0x01(bit0 blinking),0x03,…,0xFF,0x7F,…,0x01,0x00; seq_done pulse at step-0 return after 64 cycles.
- Mode 1 then mode 2: CHASE 0x01→0x80→0x01 wraps every 8 steps; BOUNCE 0x01…0x80…0x02, 14 steps, no repeat of 0x80 or 0x01 at turns.
- stop asserted at step 5 of FILL_DRAIN: continues to step 15, then led=0, busy=0 the cycle seq_done pulses.
- pause held 10 cycles at step 3: led low bits 0x07 steady, bit3 blinks every 2 cycles, step duration extends to 14 cycles.
- mode changed 0→3 at step 4: FILL_DRAIN completes, next sequence alternates 0xFF/0x00.
- rst asserted mid-RUN: led=0, busy=0, seq_done=0 asynchronously; start afterwards restarts at step 0.

Source files
------------

// File: rtl/led_bar_anim_pkg.sv
// Shared types for the LED-bar animation engine.
//   mode_e  : selectable animation sequence (2 bits, all codes valid)
//   state_e : top-level control state
package led_anim_pkg;

  typedef enum logic [1:0] {
    MODE_FILL_DRAIN = 2'd0,
    MODE_CHASE      = 2'd1,
    MODE_BOUNCE     = 2'd2,
    MODE_BLINK_ALL  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/led_bar_anim_if.sv
// Control/status bundle of the LED-bar animator.
//   start, stop, pause, mode : requests from the controller (master)
//   led, busy, seq_done      : registered status/pattern from the animator (slave)
interface led_bar_anim_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             seq_done;

  modport master (
    output start, stop, pause, mode,
    input  led, busy, seq_done
  );

  modport slave (
    input  start, stop, pause, mode,
    output led, busy, seq_done
  );
endinterface

// File: rtl/led_bar_anim_step_tick.sv
// Divide-by-DIV enable generator.
//   clk, rst : clock, async active-high reset
//   en       : count enable (counter holds while low)
//   clr      : synchronous clear to 0, overrides en
//   tick     : high while counter = DIV-1 and en is high
module step_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt;

  assign tick = en && (cnt == CntW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CntW'(1);
    end
  end
endmodule

// File: rtl/led_bar_anim.sv
// LED-bar animation engine: steps a WIDTH-bit pattern through one of four sequences,
// one step every TICK_DIV cycles, with a blinking head LED in FILL_DRAIN.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of led_bar_anim_if (start/stop/pause/mode in, led/busy/seq_done out)
module led_bar_anim
  import led_anim_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned BLINK_DIV = 2
) (
  input  logic           clk,
  input  logic           rst,
  led_bar_anim_if.slave  bus
);
  localparam int unsigned PosW = $clog2(2 * WIDTH);
  localparam int          W    = int'(WIDTH);

  state_e           state;
  mode_e            mode_q;
  logic [PosW-1:0]  pos;
  logic             stop_q;
  logic             blink;
  logic [WIDTH-1:0] led_q;
  logic             busy_q;
  logic             seq_done_q;

  logic step_t, blink_t, blink_d, wrap;
  mode_e mode_in;

  step_tick #(.DIV(TICK_DIV)) u_step (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_RUN && !bus.pause),
    .clr  (state == ST_IDLE),
    .tick (step_t)
  );

  step_tick #(.DIV(BLINK_DIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (1'b0),
    .tick (blink_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink <= 1'b0;
    else     blink <= blink ^ blink_t;
  end

  // Pattern is built from next-cycle blink so the head bit matches blink as seen on the bus.
  assign blink_d = blink ^ blink_t;
  assign mode_in = mode_e'(bus.mode);

  function automatic logic [PosW-1:0] last_pos(mode_e m);
    unique case (m)
      MODE_FILL_DRAIN: last_pos = PosW'(2 * W - 1);
      MODE_CHASE:      last_pos = PosW'(W - 1);
      MODE_BOUNCE:     last_pos = PosW'(2 * W - 3);
      default:         last_pos = PosW'(1);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] decode(mode_e m, logic [PosW-1:0] k, logic b);
    logic [WIDTH-1:0] r;
    logic             on;
    int               kk;
    kk = int'({1'b0, k});
    r  = '0;
    // Shift bits in MSB first to avoid variable bit indexing.
    for (int i = W - 1; i >= 0; i--) begin
      unique case (m)
        MODE_FILL_DRAIN: on = (kk < W) ? ((i < kk) || (i == kk && b)) : (i + kk < 2 * W - 1);
        MODE_CHASE:      on = (i == kk);
        MODE_BOUNCE:     on = (kk < W) ? (i == kk) : (i + kk == 2 * W - 2);
        default:         on = (kk == 0);
      endcase
      r = {r[WIDTH-2:0], on};
    end
    return r;
  endfunction

  assign wrap = step_t && (pos == last_pos(mode_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_FILL_DRAIN;
      pos        <= '0;
      stop_q     <= 1'b0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          pos        <= '0;
          stop_q     <= 1'b0;
          seq_done_q <= 1'b0;
          if (bus.start) begin
            state  <= ST_RUN;
            mode_q <= mode_in;
            busy_q <= 1'b1;
            led_q  <= decode(mode_in, '0, blink_d);
          end else begin
            busy_q <= 1'b0;
            led_q  <= '0;
          end
        end
        ST_RUN: begin
          seq_done_q <= wrap;
          if (bus.stop) stop_q <= 1'b1;
          if (wrap) begin
            pos    <= '0;
            mode_q <= mode_in;
            // A stop seen in this same cycle still ends the run at this wrap.
            if (stop_q || bus.stop) begin
              state  <= ST_IDLE;
              stop_q <= 1'b0;
              busy_q <= 1'b0;
              led_q  <= '0;
            end else begin
              led_q <= decode(mode_in, '0, blink_d);
            end
          end else if (step_t) begin
            pos   <= pos + PosW'(1);
            led_q <= decode(mode_q, pos + PosW'(1), blink_d);
          end else begin
            led_q <= decode(mode_q, pos, blink_d);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.seq_done = seq_done_q;
endmodule

// File: tb/tb_led_bar_anim.sv
module tb_led_bar_anim;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;
  int   c = 0;   // cycles since the latest start edge
  int   n = 0;   // clock edges since reset release (blink model)

  led_bar_anim_if #(.WIDTH(8)) bus ();

  led_bar_anim #(.WIDTH(8), .TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  logic [7:0] fd_base [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [7:0] chase_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] bounce_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
  logic [7:0] head_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  function automatic logic blink_now();
    return n[1];
  endfunction

  function automatic logic [7:0] exp_fd(int k);
    logic [7:0] v;
    v = fd_base[k];
    if (k < 8 && blink_now()) v = v | head_tab[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic do_start(input logic [1:0] m, input logic with_stop);
    bus.mode  = m;
    bus.start = 1'b1;
    bus.stop  = with_stop;
    step();
    c = 0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    bus.mode  = 2'd0;
    step();
    step();
    chk("rst_led", 32'(bus.led), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.seq_done), 32'h0);
    rst = 1'b0;
    step();
    step();
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // FILL_DRAIN full pass, then a second pass with mode switched to BLINK_ALL at step 4
    do_start(2'd0, 1'b0);
    while (c < 128) begin
      chk("fd_led", 32'(bus.led), 32'(exp_fd((c % 64) / 4)));
      chk("fd_busy", 32'(bus.busy), 32'h1);
      chk("fd_done", 32'(bus.seq_done), (c == 64) ? 32'h1 : 32'h0);
      if (c == 80) bus.mode = 2'd3;
      step();
    end
    while (c < 144) begin
      chk("ba_led", 32'(bus.led), (((c - 128) / 4) % 2 == 0) ? 32'hFF : 32'h00);
      chk("ba_done", 32'(bus.seq_done), ((c - 128) % 8 == 0) ? 32'h1 : 32'h0);
      if (c == 137) bus.stop = 1'b1;
      if (c == 138) bus.stop = 1'b0;
      step();
    end
    chk("ba_stop_led", 32'(bus.led), 32'h00);
    chk("ba_stop_busy", 32'(bus.busy), 32'h0);
    chk("ba_stop_done", 32'(bus.seq_done), 32'h1);
    bus.stop = 1'b1;   // stop while IDLE is ignored
    step();
    bus.stop = 1'b0;
    chk("idle_done", 32'(bus.seq_done), 32'h0);
    chk("idle_stop_busy", 32'(bus.busy), 32'h0);

    // CHASE then BOUNCE (mode change takes effect at the wrap), stop during BOUNCE
    do_start(2'd1, 1'b0);
    bus.mode = 2'd2;
    while (c < 144) begin
      if (c < 32) chk("chase_led", 32'(bus.led), 32'(chase_tab[c / 4]));
      else        chk("bounce_led", 32'(bus.led), 32'(bounce_tab[((c - 32) % 56) / 4]));
      chk("cb_done", 32'(bus.seq_done), (c == 32 || c == 88) ? 32'h1 : 32'h0);
      chk("cb_busy", 32'(bus.busy), 32'h1);
      bus.start = (c == 5);   // start while RUN is ignored
      if (c == 89) bus.stop = 1'b1;
      if (c == 90) bus.stop = 1'b0;
      step();
    end
    chk("bounce_stop_led", 32'(bus.led), 32'h00);
    chk("bounce_stop_busy", 32'(bus.busy), 32'h0);
    chk("bounce_stop_done", 32'(bus.seq_done), 32'h1);
    step();

    // FILL_DRAIN with pause held 10 cycles in step 3, stop at step 5
    do_start(2'd0, 1'b0);
    while (c < 74) begin
      int k;
      k = (c < 12) ? c / 4 : (c < 26) ? 3 : (c - 10) / 4;
      chk("pz_led", 32'(bus.led), 32'(exp_fd(k)));
      chk("pz_busy", 32'(bus.busy), 32'h1);
      chk("pz_done", 32'(bus.seq_done), 32'h0);
      if (c == 13) bus.pause = 1'b1;
      if (c == 23) bus.pause = 1'b0;
      if (c == 31) bus.stop = 1'b1;
      if (c == 32) bus.stop = 1'b0;
      step();
    end
    chk("pz_stop_led", 32'(bus.led), 32'h00);
    chk("pz_stop_busy", 32'(bus.busy), 32'h0);
    chk("pz_stop_done", 32'(bus.seq_done), 32'h1);
    step();
    chk("pz_after_done", 32'(bus.seq_done), 32'h0);

    // Asynchronous reset mid-run, then restart with start+stop together
    do_start(2'd3, 1'b0);
    step();
    step();
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_led", 32'(bus.led), 32'h00);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_done", 32'(bus.seq_done), 32'h0);
    step();
    rst = 1'b0;
    step();
    do_start(2'd1, 1'b1);
    while (c <= 32) begin
      chk("rs_led", 32'(bus.led), 32'(chase_tab[(c % 32) / 4]));
      chk("rs_busy", 32'(bus.busy), 32'h1);
      chk("rs_done", 32'(bus.seq_done), (c == 32) ? 32'h1 : 32'h0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
